sram_port_controller: RTL and testbench

//  Sits directly downstream of the UART control interface's SRAM request port: turns its

---
 rtl/sram_pkg.sv | 83 ++++++++
 rtl/sram_port_arbiter.sv | 50 +++++
 rtl/sram_port_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_port_controller.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the async SRAM port controller:
//   - FSM state encodings (legacy-compatible 3-bit constants)
//   - port identifiers PORT_A (control/UART side) and PORT_B (GDP bus side)
//   - default timing/width constants
//   - grant record produced by the IDLE-time arbiter
//   - strobe decode helper mapping an FSM state to the chip strobes
// -----------------------------------------------------------------------------
package sram_pkg;

   localparam int unsigned DATA_W            = 16;
   localparam int unsigned CNT_W             = 4;
   localparam int unsigned DEF_ADDR_W        = 16;
   localparam int unsigned DEF_RD_CYCLES     = 2;
   localparam int unsigned DEF_WR_CYCLES     = 2;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WR_SETUP = 3'd1;
   localparam logic [2:0] ST_WR_PULSE = 3'd2;
   localparam logic [2:0] ST_WR_HOLD  = 3'd3;
   localparam logic [2:0] ST_RD       = 3'd4;
   localparam logic [2:0] ST_RD_DONE  = 3'd5;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef struct packed {
      logic vld;   // a request was accepted this cycle
      logic port;  // PORT_A or PORT_B
      logic wr;    // 1 = write cycle, 0 = read cycle
   } grant_t;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic dq_oe;  // controller drives the data bus
   } strobe_t;

   // Phase counters count down from N-1 and advance the FSM on zero.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
      return CNT_W'(cycles - 1);
   endfunction

   // RD_DONE behaves like IDLE for acceptance so reads can run back to back.
   function automatic logic accept_state(input logic [2:0] st);
      return (st == ST_IDLE) || (st == ST_RD_DONE);
   endfunction

   // Chip strobes for a given state. Data is driven through the whole write
   // (setup, pulse and hold) so it is stable around both WE edges; OE is only
   // low in RD, so a write that follows a read never overlaps OE.
   function automatic strobe_t decode_strobes(input logic [2:0] st);
      strobe_t s;
      s.ce_n  = 1'b1;
      s.oe_n  = 1'b1;
      s.we_n  = 1'b1;
      s.dq_oe = 1'b0;
      case (st)
         ST_WR_SETUP: begin
            s.ce_n  = 1'b0;
            s.dq_oe = 1'b1;
         end
         ST_WR_PULSE: begin
            s.ce_n  = 1'b0;
            s.we_n  = 1'b0;
            s.dq_oe = 1'b1;
         end
         ST_WR_HOLD: begin
            s.ce_n  = 1'b0;
            s.dq_oe = 1'b1;
         end
         ST_RD: begin
            s.ce_n = 1'b0;
            s.oe_n = 1'b0;
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// IDLE-time grant logic for the two SRAM requesters. Port A (control) wins any
// tie; port B is only considered when A has nothing pending and a_req_i (A's
// lock) is low. On the same port a write beats a read.
// Ports:
//   idle_i            controller is in an accepting state (IDLE or RD_DONE)
//   a_req_i           port A lock: port B is never granted while high
//   a_wr_i, a_rd_i    port A write level / read request
//   b_wr_i, b_rd_i    port B write level / read request
//   grant_o           accepted request (valid, port, write/read)
//   b_busy_o          busy as seen by port B (controller busy or A locked)
// -----------------------------------------------------------------------------
module sram_port_arbiter
   import sram_pkg::*;
(
   input  logic   idle_i,
   input  logic   a_req_i,
   input  logic   a_wr_i,
   input  logic   a_rd_i,
   input  logic   b_wr_i,
   input  logic   b_rd_i,
   output grant_t grant_o,
   output logic   b_busy_o
);

   logic a_any;
   logic b_any;

   assign a_any = a_wr_i | a_rd_i;
   assign b_any = b_wr_i | b_rd_i;

   always_comb begin
      grant_o = '0;
      if (idle_i) begin
         if (a_any) begin
            grant_o.vld  = 1'b1;
            grant_o.port = PORT_A;
            grant_o.wr   = a_wr_i;
         end else if (b_any && !a_req_i) begin
            grant_o.vld  = 1'b1;
            grant_o.port = PORT_B;
            grant_o.wr   = b_wr_i;
         end
      end
   end

   assign b_busy_o = !idle_i | a_req_i;

endmodule

// File: rtl/sram_port_controller.sv
// -----------------------------------------------------------------------------
// sram_port_controller
// Turns level/pulse requests from the UART control port (A) and, optionally,
// the GDP bus port (B) into timed cycles on a 16-bit asynchronous SRAM.
//
// Configuration macro: SRAM_GDP_PORT_EN
//   defined   : dual port, A wins ties and can lock B out with a_req.
//   undefined : single port; B inputs ignored, b_busy=1, b_data_valid=0,
//               b_rdata=0.
//
// Parameters:
//   ADDR_W     SRAM word address width
//   RD_CYCLES  cycles with CE/OE low before read data is sampled (1..15)
//   WR_CYCLES  cycles with WE low per write (1..15)
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   a_req                            port A lock on port B
//   a_wr / a_rd                      port A write level / read request
//   a_addr, a_wdata                  port A word address / write data
//   a_rdata, a_data_valid            port A read data (held) / 1-cycle update pulse
//   a_busy                           controller not accepting
//   b_*                              same set for the GDP side
//   sram_a, sram_dq                  chip address / bidirectional data bus
//   sram_ce_n, sram_oe_n, sram_we_n  active-low chip strobes
//
// Write: IDLE -> WR_SETUP(1) -> WR_PULSE(WR_CYCLES) -> WR_HOLD(1) -> IDLE
// Read : IDLE -> RD(RD_CYCLES, dq sampled at its last edge) -> RD_DONE(1)
// -----------------------------------------------------------------------------
module sram_port_controller
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned RD_CYCLES = DEF_RD_CYCLES,
   parameter int unsigned WR_CYCLES = DEF_WR_CYCLES
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic              a_rd,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   output logic              a_busy,
   output logic              a_data_valid,
   input  logic              b_wr,
   input  logic              b_rd,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic [DATA_W-1:0] b_rdata,
   output logic              b_busy,
   output logic              b_data_valid,
   output logic [ADDR_W-1:0] sram_a,
   inout  wire  [DATA_W-1:0] sram_dq,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] a_rdata_q;
   strobe_t           strb_q;

   logic              idle;
   logic              rd_sample;
   grant_t            grant;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign idle      = accept_state(state_q);
   // Last edge of the read phase: the chip has had RD_CYCLES with OE low.
   assign rd_sample = (state_q == ST_RD) && (cnt_q == '0);

`ifdef SRAM_GDP_PORT_EN
   logic              b_busy_w;
   logic [DATA_W-1:0] b_rdata_q;

   sram_port_arbiter u_arb (
      .idle_i   (idle),
      .a_req_i  (a_req),
      .a_wr_i   (a_wr),
      .a_rd_i   (a_rd),
      .b_wr_i   (b_wr),
      .b_rd_i   (b_rd),
      .grant_o  (grant),
      .b_busy_o (b_busy_w)
   );

   assign sel_addr  = (grant.port == PORT_B) ? b_addr  : a_addr;
   assign sel_wdata = (grant.port == PORT_B) ? b_wdata : a_wdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         b_rdata_q <= '0;
      end else if (rd_sample && (owner_q == PORT_B)) begin
         b_rdata_q <= sram_dq;
      end
   end

   assign b_busy       = b_busy_w;
   assign b_data_valid = (state_q == ST_RD_DONE) && (owner_q == PORT_B);
   assign b_rdata      = b_rdata_q;
`else
   // Single-port build: only A can start a cycle, a_req has nothing to lock.
   always_comb begin
      grant = '0;
      if (idle && (a_wr || a_rd)) begin
         grant.vld  = 1'b1;
         grant.port = PORT_A;
         grant.wr   = a_wr;
      end
   end

   assign sel_addr  = a_addr;
   assign sel_wdata = a_wdata;

   wire unused_b_inputs = &{1'b0, a_req, b_wr, b_rd, b_addr, b_wdata};

   assign b_busy       = 1'b1;
   assign b_data_valid = 1'b0;
   assign b_rdata      = '0;
`endif

   // Next-state logic: accept in IDLE/RD_DONE, otherwise walk the phases.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE, ST_RD_DONE: begin
            state_d = ST_IDLE;
            if (grant.vld) begin
               owner_d = grant.port;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               if (grant.wr) begin
                  state_d = ST_WR_SETUP;
               end else begin
                  state_d = ST_RD;
                  cnt_d   = cnt_load(RD_CYCLES);
               end
            end
         end
         ST_WR_SETUP: begin
            state_d = ST_WR_PULSE;
            cnt_d   = cnt_load(WR_CYCLES);
         end
         ST_WR_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_WR_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
         end
         ST_RD: begin
            if (cnt_q == '0) begin
               state_d = ST_RD_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         owner_q <= PORT_A;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
      end
   end

   // Write data only matters while dq is driven, which reset disables.
   always_ff @(posedge clk) begin
      wdata_q <= wdata_d;
   end

   // Strobes are registered from the next state so the chip sees clean,
   // glitch-free edges aligned to clk; reset forces them inactive at once.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strb_q <= '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
      end else begin
         strb_q <= decode_strobes(state_d);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_rdata_q <= '0;
      end else if (rd_sample && (owner_q == PORT_A)) begin
         a_rdata_q <= sram_dq;
      end
   end

   assign sram_dq      = strb_q.dq_oe ? wdata_q : {DATA_W{1'bz}};
   assign sram_a       = addr_q;
   assign sram_ce_n    = strb_q.ce_n;
   assign sram_oe_n    = strb_q.oe_n;
   assign sram_we_n    = strb_q.we_n;

   assign a_busy       = !idle;
   assign a_data_valid = (state_q == ST_RD_DONE) && (owner_q == PORT_A);
   assign a_rdata      = a_rdata_q;

endmodule

// File: tb/tb_sram_port_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_port_controller
// Directed bench for sram_port_controller with a behavioural async SRAM.
// The data bus has a pull-up, so an undriven bus reads as 16'hFFFF.
// Port B scenarios depend on SRAM_GDP_PORT_EN.
// -----------------------------------------------------------------------------
module tb_sram_port_controller;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              a_req, a_wr, a_rd;
   logic [ADDR_W-1:0] a_addr;
   logic [15:0]       a_wdata;
   logic [15:0]       a_rdata;
   logic              a_busy, a_data_valid;
   logic              b_wr, b_rd;
   logic [ADDR_W-1:0] b_addr;
   logic [15:0]       b_wdata;
   logic [15:0]       b_rdata;
   logic              b_busy, b_data_valid;
   logic [ADDR_W-1:0] sram_a;
   tri1  [15:0]       sram_dq;
   logic              sram_ce_n, sram_oe_n, sram_we_n;

   logic [15:0] mem [0:65535];
   int checks   = 0;
   int failures = 0;
   int we_pulses  = 0;
   int we_low_cyc = 0;

   always #10 clk = ~clk;

   sram_port_controller #(.ADDR_W(ADDR_W), .RD_CYCLES(2), .WR_CYCLES(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_req        (a_req),
      .a_wr         (a_wr),
      .a_rd         (a_rd),
      .a_addr       (a_addr),
      .a_wdata      (a_wdata),
      .a_rdata      (a_rdata),
      .a_busy       (a_busy),
      .a_data_valid (a_data_valid),
      .b_wr         (b_wr),
      .b_rd         (b_rd),
      .b_addr       (b_addr),
      .b_wdata      (b_wdata),
      .b_rdata      (b_rdata),
      .b_busy       (b_busy),
      .b_data_valid (b_data_valid),
      .sram_a       (sram_a),
      .sram_dq      (sram_dq),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n)
   );

   // Behavioural SRAM: drives on CE&OE with WE high, latches on WE rising.
   assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a] : 16'bz;

   always @(posedge sram_we_n) if (!sram_ce_n) mem[sram_a] = sram_dq;
   always @(negedge sram_we_n) we_pulses++;
   always @(posedge clk) if (!sram_we_n) we_low_cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, l0, waited;
      mem[16'h0042] = 16'hBEEF;
      mem[16'h0300] = 16'hC0DE;
      mem[16'h0301] = 16'h1357;
      rst_n = 1'b0;
      a_req = 0; a_wr = 0; a_rd = 0; a_addr = '0; a_wdata = '0;
      b_wr = 0; b_rd = 0; b_addr = '0; b_wdata = '0;
      tick(3);

      // Reset state
      chk("rst_ce_n", sram_ce_n, 1);
      chk("rst_oe_n", sram_oe_n, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_dq_hiz", sram_dq, 16'hFFFF);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_dv", a_data_valid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_sram_a", sram_a, 0);
      chk("rst_b_dv", b_data_valid, 0);
`ifdef SRAM_GDP_PORT_EN
      chk("rst_b_busy", b_busy, 0);
`else
      chk("rst_b_busy", b_busy, 1);
`endif
      rst_n = 1'b1;
      tick(1);
      chk("idle_a_busy", a_busy, 0);

      // Write 0x00A5 to 0x1234 with a_wr held two cycles
      p0 = we_pulses; l0 = we_low_cyc;
      a_addr = 16'h1234; a_wdata = 16'h00A5; a_wr = 1;
      tick(1);
      chk("wsetup_busy", a_busy, 1);
      chk("wsetup_addr", sram_a, 16'h1234);
      chk("wsetup_ce_n", sram_ce_n, 0);
      chk("wsetup_we_n", sram_we_n, 1);
      chk("wsetup_oe_n", sram_oe_n, 1);
      chk("wsetup_dq", sram_dq, 16'h00A5);
      tick(1);
      a_wr = 0;
      chk("wpulse1_we_n", sram_we_n, 0);
      tick(1);
      chk("wpulse2_we_n", sram_we_n, 0);
      tick(1);
      chk("whold_we_n", sram_we_n, 1);
      chk("whold_ce_n", sram_ce_n, 0);
      chk("whold_dq", sram_dq, 16'h00A5);
      chk("whold_busy", a_busy, 1);
      tick(1);
      chk("wend_busy", a_busy, 0);
      chk("wend_ce_n", sram_ce_n, 1);
      chk("wend_dq_hiz", sram_dq, 16'hFFFF);
      tick(2);
      chk("w_single_pulse", we_pulses - p0, 1);
      chk("w_pulse_width", we_low_cyc - l0, 2);
      chk("w_mem", mem[16'h1234], 16'h00A5);

      // Read back 0x1234
      a_addr = 16'h1234; a_rd = 1;
      tick(1);
      a_rd = 0;
      chk("rd_busy", a_busy, 1);
      chk("rd_oe_n", sram_oe_n, 0);
      chk("rd_ce_n", sram_ce_n, 0);
      chk("rd1_dv", a_data_valid, 0);
      tick(1);
      chk("rd2_dv", a_data_valid, 0);
      tick(1);
      chk("rdone_dv", a_data_valid, 1);
      chk("rdone_rdata", a_rdata, 16'h00A5);
      chk("rdone_busy", a_busy, 0);
      chk("rdone_oe_n", sram_oe_n, 1);
      tick(1);
      chk("rpost_dv", a_data_valid, 0);
      tick(3);
      chk("rhold_rdata", a_rdata, 16'h00A5);

      // Read 0x0042, then a write accepted in RD_DONE
      a_addr = 16'h0042; a_rd = 1;
      tick(1);
      a_rd = 0;
      tick(1);
      a_wr = 1; a_addr = 16'h0050; a_wdata = 16'h5A5A;
      tick(1);
      chk("rw_dv", a_data_valid, 1);
      chk("rw_rdata", a_rdata, 16'hBEEF);
      chk("rw_oe_high", sram_oe_n, 1);
      chk("rw_dq_hiz_gap", sram_dq, 16'hFFFF);
      chk("rw_addr_held", sram_a, 16'h0042);
      tick(1);
      a_wr = 0;
      chk("rw_wsetup_oe_n", sram_oe_n, 1);
      chk("rw_wsetup_ce_n", sram_ce_n, 0);
      chk("rw_wsetup_dq", sram_dq, 16'h5A5A);
      chk("rw_wsetup_addr", sram_a, 16'h0050);
      chk("rw_wsetup_busy", a_busy, 1);
      tick(4);
      chk("rw_wend_busy", a_busy, 0);
      chk("rw_mem", mem[16'h0050], 16'h5A5A);

      // Reset during WR_PULSE
      a_addr = 16'h0077; a_wdata = 16'h1111; a_wr = 1;
      tick(1);
      a_wr = 0;
      tick(1);
      chk("abort_pre_we_n", sram_we_n, 0);
      rst_n = 1'b0;
      tick(1);
      chk("abort_ce_n", sram_ce_n, 1);
      chk("abort_oe_n", sram_oe_n, 1);
      chk("abort_we_n", sram_we_n, 1);
      chk("abort_dq_hiz", sram_dq, 16'hFFFF);
      chk("abort_busy", a_busy, 0);
      chk("abort_rdata", a_rdata, 0);
      chk("abort_sram_a", sram_a, 0);
      rst_n = 1'b1;
      tick(1);

`ifdef SRAM_GDP_PORT_EN
      // a_wr and b_rd together: A first, then B
      a_addr = 16'h0200; a_wdata = 16'h7777; a_wr = 1;
      b_addr = 16'h0300; b_rd = 1;
      tick(1);
      a_wr = 0;
      chk("tie_a_busy", a_busy, 1);
      chk("tie_b_busy", b_busy, 1);
      chk("tie_addr", sram_a, 16'h0200);
      chk("tie_dq", sram_dq, 16'h7777);
      tick(4);
      chk("tie_idle_oe_n", sram_oe_n, 1);
      tick(1);
      b_rd = 0;
      chk("tie_b_addr", sram_a, 16'h0300);
      chk("tie_b_oe_n", sram_oe_n, 0);
      chk("tie_b_busy_rd", b_busy, 1);
      tick(2);
      chk("tie_b_dv", b_data_valid, 1);
      chk("tie_b_rdata", b_rdata, 16'hC0DE);
      chk("tie_a_dv", a_data_valid, 0);
      chk("tie_a_rdata", a_rdata, 0);
      tick(1);
      chk("tie_b_dv_end", b_data_valid, 0);
      chk("tie_b_rdata_hold", b_rdata, 16'hC0DE);
      chk("tie_mem", mem[16'h0200], 16'h7777);

      // a_req locks B out until released
      a_req = 1;
      #1;
      chk("lock_b_busy", b_busy, 1);
      b_addr = 16'h0301; b_rd = 1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("lock_oe_n", sram_oe_n, 1);
         chk("lock_a_busy", a_busy, 0);
      end
      a_req = 0;
      tick(1);
      b_rd = 0;
      chk("unlock_oe_n", sram_oe_n, 0);
      chk("unlock_addr", sram_a, 16'h0301);
      waited = 0;
      while (!b_data_valid && waited < 8) begin
         tick(1);
         waited++;
      end
      chk("unlock_wait", waited, 2);
      chk("unlock_b_rdata", b_rdata, 16'h1357);
`else
      // Single-port build: B requests are ignored
      b_addr = 16'h0042; b_rd = 1; b_wr = 1; b_wdata = 16'h4444;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         chk("nob_a_busy", a_busy, 0);
         chk("nob_ce_n", sram_ce_n, 1);
         chk("nob_b_busy", b_busy, 1);
         chk("nob_b_dv", b_data_valid, 0);
         chk("nob_b_rdata", b_rdata, 0);
      end
      b_rd = 0; b_wr = 0;
      // a_req has no effect on A in this build
      a_req = 1; a_addr = 16'h0042; a_rd = 1;
      tick(1);
      a_rd = 0;
      tick(2);
      chk("nob_a_dv", a_data_valid, 1);
      chk("nob_a_rdata", a_rdata, 16'hBEEF);
      a_req = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
